// File: rtl/trivium_ctrl.sv
// trivium_ctrl: serial key loader, data strober and FWFT output FIFO wrapped around a Trivium-style core.
// Define TRIVIUM_CTRL_TIMEOUT_EN to add the WAIT_READY / COLLECT watchdog.
module trivium_ctrl #(
  parameter int BURST_LEN    = 256,
  parameter int FIFO_DEPTH   = 256,
  parameter int INIT_TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] key_in,
  input  logic        key_load,
  output logic        busy,
  output logic        err,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        core_key,
  output logic        core_strob_key,
  output logic [7:0]  core_data,
  output logic        core_strob_data,
  input  logic [7:0]  core_stream,
  input  logic        core_wt_sgn,
  input  logic [7:0]  core_sign_reg,
  output logic [1:0]  core_fifo_cnd
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] LP_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] LP_HALF = (AW+1)'(FIFO_DEPTH / 2);
  localparam logic [8:0]  LP_BURST_LAST = 9'(BURST_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, KEY_SHIFT, KEY_GAP, WAIT_READY, READY, SEND, COLLECT, DRAIN, ERROR
  } ctrlState_t;

  ctrlState_t  r_state;
  logic [79:0] r_keySh;
  logic [6:0]  r_bitCnt;
  logic [7:0]  r_coreData;
  logic [8:0]  r_burstCnt;
  logic        r_err;

  logic [7:0]  r_mem [0:FIFO_DEPTH-1];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0] r_count;
  logic [1:0]  r_fifoCnd;

  logic        w_full;
  logic        w_pop;
  logic        w_collectPush;
  logic        w_ovf;
  logic        w_push;
  logic        w_wdogExpire;
  logic [AW:0] w_countNext;
  logic        w_unusedSign;

  // Only bit 2 (core waiting for data) of the core status matters here.
  assign w_unusedSign = ^{core_sign_reg[7:3], core_sign_reg[1:0]};

  assign dout_valid    = (r_count != '0);
  assign w_full        = (r_count == LP_FULL);
  assign w_pop         = dout_valid & dout_ready;
  assign w_collectPush = (r_state == COLLECT) & core_wt_sgn;
  assign w_ovf         = w_collectPush & w_full & ~w_pop;
  assign w_push        = w_collectPush & ~w_ovf;
  assign dout          = r_mem[r_rdPtr];

  always_comb begin
    w_countNext = r_count;
    if (w_push && !w_pop)
      w_countNext = r_count + 1'b1;
    else if (!w_push && w_pop)
      w_countNext = r_count - 1'b1;
  end

  function automatic logic [1:0] cndOf(input logic [AW:0] c);
    if (c == '0)           return 2'b00;
    else if (c == LP_FULL) return 2'b11;
    else if (c >= LP_HALF) return 2'b10;
    else                   return 2'b01;
  endfunction

`ifdef TRIVIUM_CTRL_TIMEOUT_EN
  localparam int WW = $clog2(INIT_TIMEOUT + 1);
  localparam logic [WW-1:0] LP_WD_LAST = WW'(INIT_TIMEOUT - 1);
  logic [WW-1:0] r_wdog;

  assign w_wdogExpire = (r_wdog == LP_WD_LAST) &&
                        ((r_state == WAIT_READY && !core_sign_reg[2]) ||
                         (r_state == COLLECT && !w_collectPush));

  // Counts idle cycles in the two waiting states; any exit or push restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_wdog <= '0;
    else if (w_wdogExpire || w_collectPush ||
             !(r_state == WAIT_READY || r_state == COLLECT) ||
             (r_state == WAIT_READY && core_sign_reg[2]))
      r_wdog <= '0;
    else
      r_wdog <= r_wdog + 1'b1;
  end
`else
  assign w_wdogExpire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_keySh    <= '0;
      r_bitCnt   <= '0;
      r_coreData <= '0;
      r_burstCnt <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (key_load) begin
            r_keySh  <= key_in;
            r_bitCnt <= '0;
            r_state  <= KEY_SHIFT;
          end
        end
        KEY_SHIFT: begin
          r_keySh <= {r_keySh[78:0], 1'b0};
          if (r_bitCnt == 7'd79) begin
            r_bitCnt <= '0;
            r_state  <= KEY_GAP;
          end else begin
            r_bitCnt <= r_bitCnt + 1'b1;
          end
        end
        KEY_GAP: r_state <= WAIT_READY;
        WAIT_READY: begin
          if (core_sign_reg[2]) begin
            r_state <= READY;
          end else if (w_wdogExpire) begin
            r_err   <= 1'b1;
            r_state <= ERROR;
          end
        end
        READY: begin
          if (din_valid) begin
            r_coreData <= din;
            r_state    <= SEND;
          end
        end
        SEND: r_state <= COLLECT;
        COLLECT: begin
          if (w_ovf) begin
            r_err      <= 1'b1;
            r_burstCnt <= '0;
            r_state    <= ERROR;
          end else if (w_push) begin
            if (r_burstCnt == LP_BURST_LAST) begin
              r_burstCnt <= '0;
              r_state    <= DRAIN;
            end else begin
              r_burstCnt <= r_burstCnt + 1'b1;
            end
          end else if (w_wdogExpire) begin
            r_err      <= 1'b1;
            r_burstCnt <= '0;
            r_state    <= ERROR;
          end
        end
        DRAIN: begin
          if (w_countNext == '0)
            r_state <= READY;
        end
        ERROR: begin
          if (key_load) begin
            r_err    <= 1'b0;
            r_keySh  <= key_in;
            r_bitCnt <= '0;
            r_state  <= KEY_SHIFT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_fifoCnd <= 2'b00;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count   <= w_countNext;
      r_fifoCnd <= cndOf(w_countNext);
    end
  end

  // Storage needs no reset: emptiness is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wrPtr] <= core_stream;
  end

  assign busy            = !(r_state == IDLE || r_state == READY || r_state == ERROR);
  assign din_ready       = (r_state == READY);
  assign core_strob_key  = (r_state == KEY_SHIFT);
  assign core_key        = core_strob_key & r_keySh[79];
  assign core_strob_data = (r_state == SEND);
  assign core_data       = r_coreData;
  assign err             = r_err;
  assign core_fifo_cnd   = r_fifoCnd;

endmodule

// File: tb/tb_trivium_ctrl.sv
// Randomized bench for trivium_ctrl: a queue-based FIFO/phase model checks every cycle of each burst.
// A second small instance exercises the FIFO overflow path.
module tb_trivium_ctrl;

  localparam int BL  = 256;
  localparam int FD  = 256;
  localparam int TO  = 100;
  localparam int SBL = 6;
  localparam int SFD = 4;
  localparam int PH_COLLECT = 0;
  localparam int PH_DRAIN   = 1;
  localparam int PH_READY   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [79:0] key_in = '0;
  logic        key_load = 1'b0;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        dout_ready = 1'b0;
  logic [7:0]  core_stream = '0;
  logic        core_wt_sgn = 1'b0;
  logic [7:0]  core_sign_reg = 8'h04;

  logic        busy, err, din_ready, dout_valid, core_key, core_strob_key, core_strob_data;
  logic [7:0]  dout, core_data;
  logic [1:0]  core_fifo_cnd;

  logic        sBusy, sErr, sDinReady, sDoutValid, sCoreKey, sStrobKey, sStrobData;
  logic [7:0]  sDout, sCoreData;
  logic [1:0]  sCnd;

  int compareCount  = 0;
  int mismatchCount = 0;

  always #5 clk = ~clk;

  trivium_ctrl #(.BURST_LEN(BL), .FIFO_DEPTH(FD), .INIT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .busy(busy), .err(err),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .core_key(core_key), .core_strob_key(core_strob_key),
    .core_data(core_data), .core_strob_data(core_strob_data),
    .core_stream(core_stream), .core_wt_sgn(core_wt_sgn),
    .core_sign_reg(core_sign_reg), .core_fifo_cnd(core_fifo_cnd)
  );

  trivium_ctrl #(.BURST_LEN(SBL), .FIFO_DEPTH(SFD), .INIT_TIMEOUT(TO)) dutSmall (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .busy(sBusy), .err(sErr),
    .din(din), .din_valid(din_valid), .din_ready(sDinReady),
    .dout(sDout), .dout_valid(sDoutValid), .dout_ready(dout_ready),
    .core_key(sCoreKey), .core_strob_key(sStrobKey),
    .core_data(sCoreData), .core_strob_data(sStrobData),
    .core_stream(core_stream), .core_wt_sgn(core_wt_sgn),
    .core_sign_reg(core_sign_reg), .core_fifo_cnd(sCnd)
  );

  task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // FIFO level code as seen by the core, from the occupancy alone.
  function automatic logic [1:0] cndOf(input int n, input int depth);
    if (n == 0)          return 2'b00;
    if (n == depth)      return 2'b11;
    if (n >= depth / 2)  return 2'b10;
    return 2'b01;
  endfunction

  task automatic checkZeroOutputs();
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstDinReady", din_ready, 0);
    checkOutput("rstDoutValid", dout_valid, 0);
    checkOutput("rstCoreKey", core_key, 0);
    checkOutput("rstStrobKey", core_strob_key, 0);
    checkOutput("rstStrobData", core_strob_data, 0);
    checkOutput("rstCoreData", core_data, 0);
    checkOutput("rstFifoCnd", core_fifo_cnd, 0);
  endtask

  task automatic applyKeyLoad(input logic [79:0] key);
    logic [79:0] captured;
    int strobes;
    key_in = key;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    key_in = ~key;
    captured = '0;
    strobes = 0;
    while (core_strob_key && strobes < 100) begin
      checkOutput("keyBusy", busy, 1);
      captured = {captured[78:0], core_key};
      strobes++;
      @(negedge clk);
    end
    checkOutput("keyStrobeLen", strobes, 80);
    checkOutput("keySerial", captured, key);
    checkOutput("keyGapBusy", busy, 1);
  endtask

  task automatic runBurst(input int mode, input logic [7:0] dataByte, input int abortAt);
    logic [7:0] q[$];
    logic [7:0] sb;
    logic wt, rdy;
    int pushes, pops, guard, ph;
    guard = 0;
    while (!din_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("readyBeforeBurst", din_ready, 1);
    din = dataByte;
    din_valid = 1'b1;
    core_wt_sgn = 1'b1;
    core_stream = 8'hEE;
    @(negedge clk);
    din_valid = 1'b0;
    din = ~dataByte;
    checkOutput("sendStrobe", core_strob_data, 1);
    checkOutput("sendData", core_data, dataByte);
    checkOutput("sendReadyLow", din_ready, 0);
    @(negedge clk);
    checkOutput("strobeOneCycle", core_strob_data, 0);
    checkOutput("dataHeld", core_data, dataByte);
    ph = PH_COLLECT;
    pushes = 0;
    pops = 0;
    guard = 0;
    while (ph != PH_READY && guard < 20000) begin
      if (abortAt > 0 && pushes == abortAt) begin
        rst = 1'b0;
        #1;
        checkZeroOutputs();
        core_wt_sgn = 1'b0;
        dout_ready = 1'b0;
        return;
      end
      checkOutput("doutValid", dout_valid, q.size() != 0);
      checkOutput("fifoCnd", core_fifo_cnd, cndOf(q.size(), FD));
      checkOutput("readyLow", din_ready, 0);
      checkOutput("errLow", err, 0);
      case (mode)
        0:       begin wt = 1'($urandom_range(0, 1)); rdy = 1'($urandom_range(0, 1)); end
        1:       begin wt = 1'b1; rdy = (ph == PH_DRAIN); end
        default: begin wt = 1'b1; rdy = 1'b1; end
      endcase
      if (ph == PH_DRAIN) wt = 1'($urandom_range(0, 1));
      sb = 8'($urandom);
      core_wt_sgn = wt;
      core_stream = sb;
      dout_ready = rdy;
      if (q.size() != 0 && rdy) begin
        checkOutput("doutByte", dout, q[0]);
        void'(q.pop_front());
        pops++;
      end
      if (ph == PH_COLLECT) begin
        if (wt) begin
          q.push_back(sb);
          pushes++;
          if (pushes == BL) ph = PH_DRAIN;
        end
      end else if (q.size() == 0) begin
        ph = PH_READY;
      end
      @(negedge clk);
      guard++;
    end
    checkOutput("burstFinished", ph == PH_READY, 1);
    checkOutput("readyAfterDrain", din_ready, 1);
    checkOutput("popsTotal", pops, BL);
    checkOutput("emptyAfterDrain", dout_valid, 0);
    checkOutput("noErrAfterBurst", err, 0);
    core_wt_sgn = 1'b0;
    dout_ready = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    checkZeroOutputs();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idleBusy", busy, 0);

    applyKeyLoad(80'h0123456789ABCDEF0123);
    n = 0;
    while (!din_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachReady", din_ready, 1);
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    checkOutput("keyLoadIgnoredReady", din_ready, 1);
    checkOutput("keyLoadIgnoredStrobe", core_strob_key, 0);

    runBurst(2, 8'hA5, 0);
    for (int i = 0; i < 3; i++) runBurst(0, 8'($urandom), 0);
    runBurst(1, 8'($urandom), 0);

    runBurst(1, 8'h3C, 100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("afterAbortIdle", busy, 0);

    key_in = {$urandom, $urandom, 16'($urandom)};
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("midKeyStrobe", core_strob_key, 1);
    rst = 1'b0;
    #1;
    checkZeroOutputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midKeyIdleBusy", busy, 0);
    checkOutput("midKeyIdleStrobe", core_strob_key, 0);

    applyKeyLoad({$urandom, $urandom, 16'($urandom)});
    runBurst(0, 8'($urandom), 0);

    // Core never signals readiness: watchdog fires or the FSM waits forever.
    core_sign_reg = 8'hFB;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    checkOutput("keyIgnoredInReady", core_strob_key, 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyKeyLoad(80'hFEDCBA9876543210AA55);
`ifdef TRIVIUM_CTRL_TIMEOUT_EN
    n = 0;
    @(negedge clk);
    while (!err && n < 1000) begin
      n++;
      @(negedge clk);
    end
    checkOutput("timeoutCycles", n, TO);
    checkOutput("timeoutErr", err, 1);
    checkOutput("timeoutBusy", busy, 0);
`else
    repeat (10000) @(negedge clk);
    checkOutput("waitForeverErr", err, 0);
    checkOutput("waitForeverBusy", busy, 1);
    checkOutput("waitForeverReady", din_ready, 0);
    checkOutput("waitForeverStrobe", core_strob_key, 0);
`endif

    core_sign_reg = 8'h04;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    n = 0;
    while (!sDinReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("smallReady", sDinReady, 1);
    din = 8'h77;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    checkOutput("smallSendData", sCoreData, 8'h77);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      core_wt_sgn = 1'b1;
      core_stream = 8'(8'h50 + i);
      dout_ready = 1'b0;
      @(negedge clk);
      if (i < 4) begin
        checkOutput("smallFillCnd", sCnd, cndOf(i + 1, SFD));
        checkOutput("smallFillErr", sErr, 0);
      end
    end
    core_wt_sgn = 1'b0;
    checkOutput("ovfErr", sErr, 1);
    checkOutput("ovfBusy", sBusy, 0);
    checkOutput("ovfDinReady", sDinReady, 0);
    checkOutput("ovfStrobKey", sStrobKey, 0);
    checkOutput("ovfStrobData", sStrobData, 0);
    checkOutput("ovfCnd", sCnd, 2'b11);
    checkOutput("ovfHead", sDout, 8'h50);
    @(negedge clk);
    checkOutput("ovfErrSticky", sErr, 1);
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    checkOutput("ovfErrCleared", sErr, 0);
    checkOutput("ovfRestartStrobe", sStrobKey, 1);
    checkOutput("ovfRestartBusy", sBusy, 1);
    checkOutput("ovfFifoKept", sDoutValid, 1);
    checkOutput("ovfFifoHeadKept", sDout, 8'h50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/trivium_ctrl.md
TRIVIUM_CTRL -- requirements
Module: trivium_ctrl

Interface
REQ-001 SHALL have parameters: BURST_LEN, 256, keystream bytes the core emits per data strobe; FIFO_DEPTH, 256, output FIFO entries (power of two, at least BURST_LEN); INIT_TIMEOUT, 4095, watchdog limit in cycles.
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- key_in  in  80  session key.
- key_load  in  1  single-cycle start request.
- busy  out  1  high in every state except IDLE, READY and ERROR.
- err  out  1  sticky error flag.
- din / din_valid / din_ready  in / in / out  8 / 1 / 1  plaintext byte handshake.
- dout / dout_valid / dout_ready  out / out / in  8 / 1 / 1  ciphertext FIFO head handshake.
- core_key / core_strob_key  out / out  1 / 1  serial key lane to the cipher core.
- core_data / core_strob_data  out / out  8 / 1  data byte to the core.
- core_stream / core_wt_sgn  in / in  8 / 1  core output byte and its valid.
- core_sign_reg  in  8  core status (bit2 = waiting for data).
- core_fifo_cnd  out  2  FIFO fill level reported to the core.

Function
REQ-003 SHALL implement FSM states IDLE, KEY_SHIFT, KEY_GAP, WAIT_READY, READY, SEND, COLLECT, DRAIN, ERROR.
REQ-004 IDLE: key_load=1 SHALL latch key_in and go to KEY_SHIFT; key_load SHALL be ignored in all other states except ERROR.
REQ-005 KEY_SHIFT: SHALL drive core_strob_key=1 for exactly 80 cycles, presenting key bits MSB first (bit 79 in the first cycle), then go to KEY_GAP.
REQ-006 KEY_GAP: SHALL drive core_strob_key=0 for one cycle, then go to WAIT_READY.
REQ-007 WAIT_READY: SHALL go to READY when core_sign_reg[2]=1.
REQ-008 READY: din_ready SHALL be 1 only in this state; a handshake (din_valid and din_ready) in cycle N SHALL go to SEND.
REQ-009 SEND (cycle N+1): SHALL drive core_strob_data=1 and core_data=the accepted byte for exactly one cycle, then go to COLLECT.
- core_data SHALL hold that byte until the next SEND.
REQ-010 COLLECT: each core_wt_sgn=1 SHALL push core_stream into the FIFO and increment an 9-bit burst counter.
- After BURST_LEN pushes, the counter SHALL clear and the FSM SHALL go to DRAIN.
REQ-011 DRAIN: SHALL go to READY in the cycle the FIFO becomes empty.
REQ-012 A push while the FIFO is full SHALL drop the byte, set err=1 and go to ERROR.
REQ-013 core_wt_sgn outside COLLECT SHALL be ignored.
REQ-014 ERROR: busy=0, din_ready=0 and both core strobes=0; key_load SHALL clear err and restart at KEY_SHIFT; the FIFO SHALL NOT be flushed.
REQ-015 FIFO rules:
- First-word-fall-through; dout_valid=1 whenever not empty.
- A pop occurs when dout_valid and dout_ready are both 1.
- A simultaneous push and pop SHALL leave the count unchanged, including when full.
- Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 core_fifo_cnd SHALL be registered from the FIFO count: 00 when empty; 01 when 0<count<FIFO_DEPTH/2; 10 when FIFO_DEPTH/2<=count<FIFO_DEPTH; 11 when full.

Reset
REQ-017 On rst=0 SHALL asynchronously enter IDLE with the following outputs 0: busy, err, din_ready, dout_valid, core_key, core_strob_key, core_strob_data, core_data, core_fifo_cnd; FIFO SHALL be emptied and counters cleared.
REQ-018 Reset asserted mid-KEY_SHIFT or mid-COLLECT SHALL abort immediately; no partial key or burst SHALL survive.

Configuration
REQ-019 Macro TRIVIUM_CTRL_TIMEOUT_EN defined: a watchdog SHALL count cycles in WAIT_READY, and cycles since the last push in COLLECT.
- Reaching INIT_TIMEOUT SHALL set err=1 and go to ERROR.
- The watchdog counter SHALL clear on every state change.
REQ-020 Macro undefined: no watchdog logic SHALL exist, WAIT_READY and COLLECT SHALL wait indefinitely, and only FIFO overflow SHALL set err.

Verification
REQ-021 Key load: key_in=80'h0123456789ABCDEF0123 with key_load pulse -> core_strob_key high for exactly 80 cycles, core_key serial sequence equals key_in MSB first, busy=1 throughout.
REQ-022 Single burst: din=8'hA5 accepted, core returns 256 wt_sgn bytes, dout_ready=1 -> core_strob_data pulse of exactly 1 cycle with core_data=8'hA5; 256 dout bytes in order; DRAIN then READY.
REQ-023 Backpressure: dout_ready=0 during the burst -> core_fifo_cnd steps 00,01,10,11; no err; READY only after 256 pops.
REQ-024 Overflow: FIFO_DEPTH=256, 1 stale entry, burst of 256 -> 256th push dropped, err=1, ERROR state; key_load clears err.
REQ-025 Timeout (macro defined, INIT_TIMEOUT=100): core_sign_reg[2] held 0 -> err=1 at cycle 100 of WAIT_READY; macro undefined -> still WAIT_READY after 10000 cycles.
REQ-026 Reset mid-op: rst low at KEY_SHIFT bit 40 -> all outputs 0 within the same cycle, IDLE, FIFO empty.
